// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: a step time-base drives an OFF/RUN/BLINK/BOUNCE pattern engine.
// Mode changes use a req/ack handshake and are applied only on step boundaries.
module led_seq_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_MS = 100,
  parameter int N_LED   = 4,
  parameter int CNT_W   = 23
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Mode_Req,
  input  logic [1:0]       Mode_Sel,
  input  logic             Pause,
  output logic             Mode_Ack,
  output logic [1:0]       Cur_Mode,
  output logic             Step_Tick,
  output logic [N_LED-1:0] LED_Out
);

  // Mode request handshake:
  //   Mode_Req is a level held by the requester until Mode_Ack. While no request is
  //   pending, Mode_Req=1 latches Mode_Sel; later Mode_Sel changes are ignored until the
  //   latched mode is applied at the next step boundary, where Mode_Ack pulses for one
  //   cycle. Latching is blocked during the Ack cycle, so a Mode_Req still high there is
  //   only re-latched on the following cycle (the requester normally drops it on Ack).

  localparam int STEP_CYC = CLK_HZ / 1000 * STEP_MS;
  localparam int POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_QTR = CNT_W'(STEP_CYC / 4);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_RUN    = 2'd1,
    M_BLINK  = 2'd2,
    M_BOUNCE = 2'd3
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  mode_t            state_q, state_d;
  mode_t            pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             ack_q, ack_d;
  logic             tick_q, tick_d;
  logic [N_LED-1:0] led_q, led_d;

  logic             wrap;
  logic             apply;

  // A boundary only exists when the time-base actually wraps; Pause suppresses it.
  assign wrap  = !Pause && (cnt_q == CNT_MAX);
  assign apply = wrap && pend_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= M_OFF;
      pend_mode_q <= M_OFF;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      pos_q       <= '0;
      dir_q       <= DIR_UP;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      ack_q       <= ack_d;
      tick_q      <= tick_d;
      led_q       <= led_d;
    end
  end

  // Time-base
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = wrap;
    if (!Pause) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Request capture
  always_comb begin
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    ack_d       = apply;
    if (apply) begin
      pend_d = 1'b0;
    end else if (Mode_Req && !pend_q && !ack_q) begin
      pend_d      = 1'b1;
      pend_mode_d = mode_t'(Mode_Sel);
    end
  end

  // Mode FSM and pattern position; a pending mode change takes the boundary.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    if (apply) begin
      state_d = pend_mode_q;
      pos_d   = '0;
      dir_d   = DIR_UP;
    end else if (wrap) begin
      case (state_q)
        M_RUN: begin
          pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
        end
        M_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              pos_d = pos_q - POS_ONE;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = pos_q + POS_ONE;
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        default: begin
          pos_d = pos_q;
        end
      endcase
    end
  end

  // LED drive is registered from the current state, so it trails pos/Cnt by one cycle.
  always_comb begin
    led_d = led_q;
    if (!Pause) begin
      case (state_q)
        M_OFF:    led_d = '0;
        M_RUN:    led_d = N_LED'(1) << pos_q;
        M_BLINK:  led_d = (cnt_q < CNT_QTR) ? '1 : '0;
        M_BOUNCE: led_d = N_LED'(1) << pos_q;
        default:  led_d = '0;
      endcase
    end
  end

  assign Mode_Ack  = ack_q;
  assign Cur_Mode  = state_q;
  assign Step_Tick = tick_q;
  assign LED_Out   = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl with a 10-cycle step and 4 LEDs: table of mode/pattern
// vectors plus hand-written sequences for boundary request, BLINK, Pause and reset.
module tb_led_seq_ctrl;

  localparam int N_LED = 4;

  logic             clk;
  logic             rst_n;
  logic             mode_req;
  logic [1:0]       mode_sel;
  logic             pause;
  logic             mode_ack;
  logic [1:0]       cur_mode;
  logic             step_tick;
  logic [N_LED-1:0] led_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N_LED-1:0] exp_q[$];
  logic [N_LED-1:0] last_led;

  typedef struct {
    logic [1:0]  mode;
    int          n_steps;
    int          exp_lat;
    logic [31:0] seq;     // expected LED per step, step 0 in the low nibble
  } vec_t;

  vec_t tbl[5];

  led_seq_ctrl #(
    .CLK_HZ (1000),
    .STEP_MS(10),
    .N_LED  (N_LED),
    .CNT_W  (23)
  ) dut (
    .CLK      (clk),
    .RSTn     (rst_n),
    .Mode_Req (mode_req),
    .Mode_Sel (mode_sel),
    .Pause    (pause),
    .Mode_Ack (mode_ack),
    .Cur_Mode (cur_mode),
    .Step_Tick(step_tick),
    .LED_Out  (led_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: wait for Mode_Ack (bounded), drop the request on it, return the cycle count.
  task automatic wait_ack(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (mode_ack) seen = 1'b1;
    end
    mode_req = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_timeout: no Mode_Ack within 40 cycles at %0t", $time);
    end
  endtask

  // Request a mode and check the Ack cycle: latency, Cur_Mode, Step_Tick, LED still old.
  task automatic do_mode(input logic [1:0] mode, input int exp_lat,
                         input logic [N_LED-1:0] ack_led);
    int lat;
    mode_sel = mode;
    mode_req = 1'b1;
    wait_ack(lat);
    check("ack_latency", lat, exp_lat);
    check("cur_mode_at_ack", cur_mode, mode);
    check("tick_at_ack", step_tick, 1'b1);
    check("led_at_ack", led_out, ack_led);
  endtask

  initial begin
    int lat;
    logic [N_LED-1:0] e;

    tbl[0] = '{mode: 2'd1, n_steps: 5, exp_lat: 7, seq: 32'h0001_8421};
    tbl[1] = '{mode: 2'd3, n_steps: 8, exp_lat: 9, seq: 32'h2124_8421};
    tbl[2] = '{mode: 2'd0, n_steps: 3, exp_lat: 9, seq: 32'h0000_0000};
    tbl[3] = '{mode: 2'd3, n_steps: 3, exp_lat: 9, seq: 32'h0000_0421};
    tbl[4] = '{mode: 2'd3, n_steps: 2, exp_lat: 9, seq: 32'h0000_0021};

    mode_req = 1'b0;
    mode_sel = 2'd0;
    pause    = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("reset_led", led_out, 0);
    check("reset_mode", cur_mode, 0);
    check("reset_ack", mode_ack, 0);
    check("reset_tick", step_tick, 0);

    // Idle after reset: OFF, tick every 10 cycles
    apply_reset();
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check("idle_tick", step_tick, (k % 10) == 0);
      check("idle_led", led_out, 0);
      check("idle_mode", cur_mode, 0);
    end
    repeat (3) @(negedge clk);

    // Table: request each mode, then sample LED at Cnt=1 of every step
    last_led = '0;
    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < tbl[v].n_steps; s++) exp_q.push_back(tbl[v].seq[4*s +: 4]);
      do_mode(tbl[v].mode, tbl[v].exp_lat, last_led);
      for (int s = 0; s < tbl[v].n_steps; s++) begin
        repeat ((s == 0) ? 1 : 10) @(negedge clk);
        if (s == 0) check("ack_width", mode_ack, 0);
        e = exp_q.pop_front();
        check("pattern_led", led_out, e);
        last_led = e;
      end
    end

    // Request raised on the boundary cycle: the old pattern advances once,
    // the request is applied at the following boundary.
    repeat (8) @(negedge clk);
    do_mode(2'd1, 11, 4'b0100);
    @(negedge clk);
    check("run_first_led", led_out, 4'b0001);

    // BLINK: 1111 for two cycles then 0000 for eight, lagging Cnt by one
    do_mode(2'd2, 9, 4'b0001);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      exp_q.push_back(((j % 10) == 1 || (j % 10) == 2) ? 4'b1111 : 4'b0000);
      e = exp_q.pop_front();
      check("blink_led", led_out, e);
    end

    // Pause in RUN with a request pending: everything freezes, Mode_Sel ignored
    do_mode(2'd1, 10, 4'b0000);
    repeat (3) @(negedge clk);
    check("pre_pause_led", led_out, 4'b0001);
    pause    = 1'b1;
    mode_sel = 2'd3;
    mode_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) mode_sel = 2'd2;
      check("pause_tick", step_tick, 0);
      check("pause_ack", mode_ack, 0);
      check("pause_led", led_out, 4'b0001);
    end
    pause = 1'b0;
    wait_ack(lat);
    check("resume_latency", lat, 7);
    check("resume_mode", cur_mode, 2'd3);
    check("resume_led_at_ack", led_out, 4'b0001);
    @(negedge clk);
    check("bounce_first_led", led_out, 4'b0001);

    // Reset in BOUNCE with a request pending: outputs clear at once, request lost
    repeat (3) @(negedge clk);
    mode_sel = 2'd2;
    mode_req = 1'b1;
    @(negedge clk);
    mode_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_mode", cur_mode, 0);
    check("async_rst_ack", mode_ack, 0);
    check("async_rst_tick", step_tick, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      check("post_rst_ack", mode_ack, 0);
      check("post_rst_mode", cur_mode, 0);
      check("post_rst_tick", step_tick, (k % 10) == 0);
      check("post_rst_led", led_out, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
